// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the NES sprite DMA engine.
// OAM_DMA_ALIGN_EN (see oam_dma.sv) selects the odd-cycle alignment variant.
package oam_dma_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

    // 6502 rw polarity: 1 = read, 0 = write
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Selects whether the CPU or the DMA engine drives the system bus.
module oam_dma_bus_mux (
    input  logic        busy,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_rw,
    input  logic [15:0] eng_a,
    input  logic [7:0]  eng_d,
    input  logic        eng_rw,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_d_out,
    output logic        bus_rw
);

    assign bus_a     = busy ? eng_a  : cpu_a;
    assign bus_d_out = busy ? eng_d  : cpu_d;
    assign bus_rw    = busy ? eng_rw : cpu_rw;

endmodule

// File: rtl/oam_dma.sv
// NES sprite DMA: copies page {N,00} to OAMDATA while stalling the 6502 core.
// Define OAM_DMA_ALIGN_EN to insert the extra alignment cycle when HALT lands on an odd cycle.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_d_in,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_d_out,
    output logic        bus_rw,
    output logic        rdy,
    output logic        busy
);

    dma_state_t  state, next_state;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data_buf;
    logic [15:0] eng_a;
    logic [7:0]  eng_d;
    logic        eng_rw;
    logic        trigger;

    assign trigger = (cpu_rw == RW_WRITE) && (cpu_a == DMA_REG_ADDR);
    assign busy    = (state != DMA_IDLE);
    assign rdy     = ~busy;

`ifdef OAM_DMA_ALIGN_EN
    logic parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DMA_IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            data_buf <= 8'h00;
        end else begin
            state <= next_state;
            if (state == DMA_IDLE && trigger) begin
                page <= cpu_d;
                idx  <= 8'h00;
            end
            if (state == DMA_READ) begin
                data_buf <= bus_d_in;
            end
            if (state == DMA_WRITE) begin
                idx <= idx + 8'h01;
            end
        end
    end

    // HALT/ALIGN are dummy reads at whatever address the stalled core presents
    always_comb begin
        next_state = state;
        eng_a      = cpu_a;
        eng_d      = data_buf;
        eng_rw     = RW_READ;
        case (state)
            DMA_IDLE: begin
                if (trigger) begin
                    next_state = DMA_HALT;
                end
            end
            DMA_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                next_state = parity ? DMA_ALIGN : DMA_READ;
`else
                next_state = DMA_READ;
`endif
            end
            DMA_ALIGN: begin
                next_state = DMA_READ;
            end
            DMA_READ: begin
                eng_a      = {page, idx};
                next_state = DMA_WRITE;
            end
            DMA_WRITE: begin
                eng_a      = OAM_DATA_ADDR;
                eng_rw     = RW_WRITE;
                next_state = (idx == 8'hFF) ? DMA_IDLE : DMA_READ;
            end
            default: begin
                next_state = DMA_IDLE;
            end
        endcase
    end

    oam_dma_bus_mux u_bus_mux (
        .busy      (busy),
        .cpu_a     (cpu_a),
        .cpu_d     (cpu_d),
        .cpu_rw    (cpu_rw),
        .eng_a     (eng_a),
        .eng_d     (eng_d),
        .eng_rw    (eng_rw),
        .bus_a     (bus_a),
        .bus_d_out (bus_d_out),
        .bus_rw    (bus_rw)
    );

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard testbench for oam_dma: expected source reads and OAM writes are queued at trigger
// time and consumed by a bus monitor; also checks stall length, reset abort and pass-through.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_a = 16'h0000;
    logic [7:0]  cpu_d = 8'h00;
    logic        cpu_rw = 1'b1;
    logic [7:0]  bus_d_in;
    logic [15:0] bus_a;
    logic [7:0]  bus_d_out;
    logic        bus_rw;
    logic        rdy;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_addr_q [$];
    logic [7:0]  exp_data_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int oam_writes = 0;
    int run_reads = 0;
    int first_read_cyc = 0;
    int zero_hits = 0;
    logic par_model;
    int align_en;

    localparam logic [15:0] STALL_A = 16'h1234;

    oam_dma dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_a     (cpu_a),
        .cpu_d     (cpu_d),
        .cpu_rw    (cpu_rw),
        .bus_d_in  (bus_d_in),
        .bus_a     (bus_a),
        .bus_d_out (bus_d_out),
        .bus_rw    (bus_rw),
        .rdy       (rdy),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign bus_d_in = mem[bus_a];

    always @(posedge clk) cyc <= cyc + 1;

    // Parity of the cycle following each edge; an odd HALT cycle adds the ALIGN cycle
    always @(posedge clk or posedge rst) begin
        if (rst) par_model <= 1'b0;
        else     par_model <= ~par_model;
    end

    function automatic logic [7:0] memValue(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
        return a[7:0] + (a[15:8] * 8'd3) + 8'h11;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic rw, input logic [7:0] d);
        cpu_a  = a;
        cpu_rw = rw;
        cpu_d  = d;
    endtask

    // Bus monitor: while the engine owns the bus, writes must be OAM stores and
    // any access away from the stalled CPU address must be the next source read
    always @(negedge clk) begin
        if (busy && !rst) begin
            if (bus_a == 16'h0000) zero_hits++;
            if (bus_rw == 1'b0) begin
                oam_writes++;
                checkOutput("oam_wr_addr", {16'h0, bus_a}, 32'h2004);
                if (exp_data_q.size() > 0)
                    checkOutput("oam_wr_data", {24'h0, bus_d_out}, {24'h0, exp_data_q.pop_front()});
                else
                    checkOutput("unexpected_write", 32'd1, 32'd0);
            end else if (bus_a != cpu_a) begin
                if (run_reads == 0) first_read_cyc = cyc;
                run_reads++;
                if (exp_addr_q.size() > 0)
                    checkOutput("src_rd_addr", {16'h0, bus_a}, {16'h0, exp_addr_q.pop_front()});
                else
                    checkOutput("unexpected_read", 32'd1, 32'd0);
            end
        end
    end

    task automatic pushExpected(input logic [7:0] page);
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < 256; i++) begin
            logic [15:0] a;
            a = {page, i[7:0]};
            exp_addr_q.push_back(a);
            exp_data_q.push_back(memValue(a));
        end
    endtask

    // Advance until the HALT that follows a trigger issued now would have the requested parity
    task automatic alignTo(input logic halt_odd);
        @(posedge clk); #1;
        if ((~par_model) != halt_odd) begin
            @(posedge clk); #1;
        end
    endtask

    // Must be entered at #1 after a rising edge
    task automatic runDma(input logic [7:0] page, input string tag);
        int trig_cyc;
        int low;
        int exp_len;
        int exp_first;
        applyStimulus(16'h4014, 1'b0, page);
        @(negedge clk);
        checkOutput({tag, "_trig_pass_a"}, {16'h0, bus_a}, 32'h4014);
        checkOutput({tag, "_trig_pass_d"}, {24'h0, bus_d_out}, {24'h0, page});
        checkOutput({tag, "_trig_busy"}, {31'h0, busy}, 32'd0);
        trig_cyc  = cyc;
        run_reads = 0;
        pushExpected(page);
        @(posedge clk); #1;
        applyStimulus(STALL_A, 1'b1, 8'h00);
        @(negedge clk);
        exp_len   = 513 + ((align_en != 0 && par_model) ? 1 : 0);
        exp_first = 2 + ((align_en != 0 && par_model) ? 1 : 0);
        checkOutput({tag, "_halt_bus_a"}, {16'h0, bus_a}, {16'h0, STALL_A});
        low = 0;
        while (rdy == 1'b0 && low < 700) begin
            low++;
            @(negedge clk);
        end
        if (low >= 700) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
        checkOutput({tag, "_rdy_low_cycles"}, low, exp_len);
        checkOutput({tag, "_first_read_ofs"}, first_read_cyc - trig_cyc, exp_first);
        checkOutput({tag, "_reads"}, run_reads, 256);
        checkOutput({tag, "_addr_q_left"}, exp_addr_q.size(), 0);
        checkOutput({tag, "_data_q_left"}, exp_data_q.size(), 0);
        checkOutput({tag, "_end_busy"}, {31'h0, busy}, 32'd0);
        checkOutput({tag, "_end_pass_a"}, {16'h0, bus_a}, {16'h0, cpu_a});
    endtask

    initial begin
        int guard;
        int base;
`ifdef OAM_DMA_ALIGN_EN
        align_en = 1;
`else
        align_en = 0;
`endif
        for (int a = 0; a < 65536; a++) mem[a] = memValue(a[15:0]);

        // Power-on reset
        #1;
        checkOutput("por_rdy", {31'h0, rdy}, 32'd1);
        checkOutput("por_busy", {31'h0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Main transfers, page 02, both HALT parities
        alignTo(1'b1);
        runDma(8'h02, "p02_odd");
        alignTo(1'b0);
        runDma(8'h02, "p02_even");

        // Page FF: last read $FFFF, never $0000
        zero_hits = 0;
        alignTo(1'b0);
        runDma(8'hFF, "pFF");
        checkOutput("pFF_zero_access", zero_hits, 0);

        // Reset mid-transfer at transfer 100
        @(posedge clk); #1;
        applyStimulus(16'h4014, 1'b0, 8'h05);
        pushExpected(8'h05);
        run_reads = 0;
        base = oam_writes;
        @(posedge clk); #1;
        applyStimulus(STALL_A, 1'b1, 8'h00);
        guard = 0;
        while (oam_writes - base < 100 && guard < 700) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 700) checkOutput("abort_timeout", 32'd1, 32'd0);
        checkOutput("abort_reads_before", run_reads, 100);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_rdy", {31'h0, rdy}, 32'd1);
        checkOutput("abort_busy", {31'h0, busy}, 32'd0);
        checkOutput("abort_pass_a", {16'h0, bus_a}, {16'h0, STALL_A});
        exp_addr_q.delete();
        exp_data_q.delete();
        base = oam_writes;

        // Reset held: pass-through must track the CPU with no engine activity
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            applyStimulus(16'h0300 + i[15:0], i[0], 8'hA0 + i[7:0]);
            @(negedge clk);
            checkOutput("rst_hold_rdy", {31'h0, rdy}, 32'd1);
            checkOutput("rst_hold_a", {16'h0, bus_a}, {16'h0300 + i[15:0]});
            checkOutput("rst_hold_rw", {31'h0, bus_rw}, {31'h0, i[0]});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(STALL_A, 1'b1, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("abort_no_more_oam", oam_writes - base, 0);
        alignTo(1'b1);
        runDma(8'h05, "restart");

        // Non-trigger traffic near the DMA register
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a;
            logic        rw;
            a  = (i == 0) ? 16'h4013 : (i == 1) ? 16'h4015 : 16'h4014;
            rw = (i == 2);
            @(posedge clk); #1;
            applyStimulus(a, rw, 8'h3C + i[7:0]);
            @(negedge clk);
            checkOutput("nt_pass_a", {16'h0, bus_a}, {16'h0, a});
            checkOutput("nt_pass_rw", {31'h0, bus_rw}, {31'h0, rw});
            checkOutput("nt_pass_d", {24'h0, bus_d_out}, {24'h0, 8'h3C + i[7:0]});
            @(negedge clk);
            checkOutput("nt_busy", {31'h0, busy}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
